muldiv_unit: RTL and testbench

- Iterative multiply/divide unit with HI/LO registers for the pipelined MIPS core.
- Sits beside the ALU in the EX stage and adds MULT/MULTU/DIV/DIVU/MTHI/MTLO; MFHI/MFLO read o_hi/o_lo.
- o_busy drives the hazard logic, which freezes PC, IF/ID and ID/EX while an operation is in flight.
- Generalised over operand width; one shared shift/add-subtract datapath serves both multiply and divide.

---
 rtl/muldiv_pkg.sv | 21 ++
 rtl/muldiv_step.sv | 39 +++
 rtl/muldiv_unit.sv | 137 +++++++++++++
 tb/tb_muldiv_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// The step module and the top-level control both import this package.
package muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add for multiply,
// restoring shift-subtract for divide, over the {hi, lo} working pair.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             mode,
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    always_comb begin
        sum    = {1'b0, hi_in} + (lo_in[0] ? {1'b0, opnd} : '0);
        rem_sh = {hi_in, lo_in[WIDTH-1]};
        diff   = rem_sh - {1'b0, opnd};
        hi_out = '0;
        lo_out = '0;
        if (mode == MODE_MUL) begin
            hi_out = sum[WIDTH:1];
            lo_out = {sum[0], lo_in[WIDTH-1:1]};
        end else if (!diff[WIDTH]) begin
            // No borrow: the trial subtraction stands and the quotient bit is 1.
            hi_out = diff[WIDTH-1:0];
            lo_out = {lo_in[WIDTH-2:0], 1'b1};
        end else begin
            hi_out = rem_sh[WIDTH-1:0];
            lo_out = {lo_in[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO unit with HI/LO registers.
// Works on magnitudes, then applies the sign correction in a final FIX cycle.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [2:0]       i_op,
    input  logic             i_cancel,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc, lo_w, opnd;
    logic is_div, neg_lo, neg_hi, div0;
    logic load, fix, mt_hi, mt_lo;
    logic signed_op, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag, step_hi, step_lo;
    logic [WIDTH-1:0] quo_fix, rem_fix;
    logic [2*WIDTH-1:0] prod, prod_fix;

    always_comb begin
        state_next = state;
        load  = 1'b0;
        fix   = 1'b0;
        mt_hi = 1'b0;
        mt_lo = 1'b0;
        if (i_cancel) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        case (i_op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                load       = 1'b1;
                                state_next = S_CALC;
                            end
                            OP_MTHI: mt_hi = 1'b1;
                            OP_MTLO: mt_lo = 1'b1;
                            default: ;
                        endcase
                    end
                end
                S_CALC:  if (cnt == CNT_W'(WIDTH - 1)) state_next = S_FIX;
                S_FIX: begin
                    fix        = 1'b1;
                    state_next = S_IDLE;
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        signed_op = (i_op == OP_MULT) || (i_op == OP_DIV);
        a_neg     = signed_op & i_a[WIDTH-1];
        b_neg     = signed_op & i_b[WIDTH-1];
        a_mag     = a_neg ? -i_a : i_a;
        b_mag     = b_neg ? -i_b : i_b;
        prod      = {acc, lo_w};
        prod_fix  = neg_lo ? -prod : prod;
        // Signed quotient truncates toward zero; remainder follows the dividend.
        quo_fix   = div0 ? '1 : (neg_lo ? -lo_w : lo_w);
        rem_fix   = neg_hi ? -acc : acc;
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .mode   (is_div ? MODE_DIV : MODE_MUL),
        .hi_in  (acc),
        .lo_in  (lo_w),
        .opnd   (opnd),
        .hi_out (step_hi),
        .lo_out (step_lo)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            acc    <= '0;
            lo_w   <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            div0   <= 1'b0;
            o_busy <= 1'b0;
            o_done <= 1'b0;
            o_hi   <= '0;
            o_lo   <= '0;
        end else begin
            o_busy <= (state_next != S_IDLE);
            o_done <= fix;
            if (load) begin
                is_div <= (i_op == OP_DIV) || (i_op == OP_DIVU);
                cnt    <= '0;
                acc    <= '0;
                lo_w   <= (i_op == OP_DIV || i_op == OP_DIVU) ? a_mag : b_mag;
                opnd   <= (i_op == OP_DIV || i_op == OP_DIVU) ? b_mag : a_mag;
                neg_lo <= a_neg ^ b_neg;
                neg_hi <= a_neg;
                div0   <= (i_b == '0);
            end else if (state == S_CALC) begin
                acc  <= step_hi;
                lo_w <= step_lo;
                cnt  <= cnt + CNT_W'(1);
            end
            if (mt_hi) o_hi <= i_a;
            if (mt_lo) o_lo <= i_a;
            if (fix) begin
                if (is_div) begin
                    o_lo <= quo_fix;
                    o_hi <= rem_fix;
                end else begin
                    {o_hi, o_lo} <= prod_fix;
                end
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed cases, control sequencing and random
// operations checked against a plain-arithmetic reference of HI/LO.
module tb_muldiv_unit;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset, i_start, i_cancel;
    logic [2:0] i_op;
    logic [W-1:0] i_a, i_b;
    logic o_busy, o_done;
    logic [W-1:0] o_hi, o_lo;

    int n_checks = 0;
    int n_fails  = 0;
    logic [W-1:0] model_hi, model_lo;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .i_start  (i_start),
        .i_op     (i_op),
        .i_cancel (i_cancel),
        .i_a      (i_a),
        .i_b      (i_b),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_hi     (o_hi),
        .o_lo     (o_lo)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: MIPS HI/LO results from ordinary 64-bit arithmetic.
    function automatic void ref_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] hi, output logic [W-1:0] lo);
        longint sa, sb;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        hi = model_hi;
        lo = model_lo;
        case (op)
            3'd0: {hi, lo} = sa * sb;
            3'd1: {hi, lo} = ua * ub;
            3'd2, 3'd3: begin
                if (b == '0) begin
                    lo = '1;
                    hi = a;
                end else if (op == 3'd2) begin
                    lo = W'(sa / sb);
                    hi = W'(sa % sb);
                end else begin
                    lo = W'(ua / ub);
                    hi = W'(ua % ub);
                end
            end
            default: ;
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit intrude);
        logic [W-1:0] eh, el;
        int cycles, dones;
        ref_op(op, a, b, eh, el);
        @(negedge clk);
        i_start = 1'b1; i_op = op; i_a = a; i_b = b;
        @(negedge clk);
        i_start = 1'b0;
        cycles = 0;
        dones  = 0;
        while (o_busy && cycles < 100) begin
            cycles++;
            if (o_done) dones++;
            if (intrude && cycles == 3) begin
                i_start = 1'b1; i_op = 3'd2; i_a = $urandom; i_b = 32'd1;
            end else begin
                i_start = 1'b0;
            end
            @(negedge clk);
        end
        i_start = 1'b0;
        check({tag, "_busy_cycles"}, 64'(cycles), 64'd33);
        check({tag, "_done"}, {63'b0, o_done}, 64'd1);
        check({tag, "_hi"}, {32'b0, o_hi}, {32'b0, eh});
        check({tag, "_lo"}, {32'b0, o_lo}, {32'b0, el});
        @(negedge clk);
        check({tag, "_done_once"}, 64'(dones + int'(o_done)), 64'd0);
        model_hi = eh;
        model_lo = el;
    endtask

    initial begin
        int dones;
        logic [2:0] rop;
        logic [W-1:0] ra, rb;
        reset = 1'b0; i_start = 1'b0; i_cancel = 1'b0; i_op = '0; i_a = '0; i_b = '0;
        model_hi = '0; model_lo = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {63'b0, o_busy}, 64'd0);
        check("rst_done", {63'b0, o_done}, 64'd0);
        check("rst_hi", {32'b0, o_hi}, 64'd0);
        check("rst_lo", {32'b0, o_lo}, 64'd0);
        reset = 1'b1;

        run_op("mult_neg3x7", 3'd0, -32'sd3, 32'd7, 1'b0);
        check("mult_neg3x7_hi_const", {32'b0, o_hi}, 64'hFFFF_FFFF);
        check("mult_neg3x7_lo_const", {32'b0, o_lo}, 64'hFFFF_FFEB);
        run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("multu_max_hi_const", {32'b0, o_hi}, 64'hFFFF_FFFE);
        run_op("div_neg7_2", 3'd2, -32'sd7, 32'd2, 1'b0);
        check("div_neg7_2_lo_const", {32'b0, o_lo}, 64'hFFFF_FFFD);
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("div_ovf_lo_const", {32'b0, o_lo}, 64'h8000_0000);
        run_op("divu_by0", 3'd3, 32'd5, 32'd0, 1'b0);
        check("divu_by0_hi_const", {32'b0, o_hi}, 64'd5);
        run_op("div_neg_by0", 3'd2, -32'sd9, 32'd0, 1'b0);

        // MTHI writes at the issue edge with no busy and no done.
        @(negedge clk);
        i_start = 1'b1; i_op = 3'd4; i_a = 32'h1234;
        @(negedge clk);
        i_start = 1'b0;
        check("mthi_hi", {32'b0, o_hi}, 64'h1234);
        check("mthi_lo_kept", {32'b0, o_lo}, {32'b0, model_lo});
        check("mthi_busy", {63'b0, o_busy}, 64'd0);
        check("mthi_done", {63'b0, o_done}, 64'd0);
        model_hi = 32'h1234;

        // MTLO together with cancel is suppressed.
        i_start = 1'b1; i_op = 3'd5; i_a = 32'hDEAD_BEEF; i_cancel = 1'b1;
        @(negedge clk);
        i_start = 1'b0; i_cancel = 1'b0;
        check("mtlo_cancel_lo", {32'b0, o_lo}, {32'b0, model_lo});

        // Opcode 6 is a no-op.
        i_start = 1'b1; i_op = 3'd6; i_a = 32'h5555_5555;
        @(negedge clk);
        i_start = 1'b0;
        check("nop_busy", {63'b0, o_busy}, 64'd0);
        check("nop_hi", {32'b0, o_hi}, {32'b0, model_hi});
        check("nop_lo", {32'b0, o_lo}, {32'b0, model_lo});

        // DIVU cancelled after ten cycles in flight.
        i_start = 1'b1; i_op = 3'd3; i_a = 32'd1000; i_b = 32'd7;
        @(negedge clk);
        i_start = 1'b0;
        repeat (9) @(negedge clk);
        check("cancel_busy_before", {63'b0, o_busy}, 64'd1);
        i_cancel = 1'b1;
        @(negedge clk);
        i_cancel = 1'b0;
        check("cancel_busy", {63'b0, o_busy}, 64'd0);
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            if (o_done) dones++;
            @(negedge clk);
        end
        check("cancel_no_done", 64'(dones), 64'd0);
        check("cancel_hi", {32'b0, o_hi}, {32'b0, model_hi});
        check("cancel_lo", {32'b0, o_lo}, {32'b0, model_lo});

        // Reset in the middle of a MULT clears everything at once.
        i_start = 1'b1; i_op = 3'd0; i_a = 32'd12345; i_b = 32'd678;
        @(negedge clk);
        i_start = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrst_busy", {63'b0, o_busy}, 64'd0);
        check("midrst_done", {63'b0, o_done}, 64'd0);
        check("midrst_hi", {32'b0, o_hi}, 64'd0);
        check("midrst_lo", {32'b0, o_lo}, 64'd0);
        model_hi = '0; model_lo = '0;
        @(negedge clk);
        reset = 1'b1;

        run_op("intrude", 3'd0, 32'hFFFF_0000, 32'h0001_0003, 1'b1);

        for (int k = 0; k < 24; k++) begin
            rop = 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 5))
                0: rb = '0;
                1: begin ra = 32'h8000_0000; rb = '1; end
                2: begin
                    ra = 32'($urandom_range(0, 40)) - 32'd20;
                    rb = 32'($urandom_range(0, 10)) - 32'd5;
                end
                default: ;
            endcase
            run_op($sformatf("rnd%0d", k), rop, ra, rb, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
